// File: rtl/sram_rmw_ctrl.sv
// rtl/sram_rmw_ctrl.sv - read-modify-write front end for a single-port SRAM macro without bit enables
//
// Optional feature macro: SRAM_RMW_PARITY_EN. When it is defined, each byte carries an even-parity bit in the macro.
//
// Ports:
//   clk_i, rst_ni        clock; synchronous active-low reset
//   req_i/gnt_o          upstream request and grant; the grant is combinational
//   we_i, addr_i         write/read select and word address
//   wdata_i, wmask_i     write data and byte-uniform bit mask
//   rdata_o, rvalid_o    read data, valid one cycle after a granted read
//   rerror_o             {uncorrectable parity, correctable (always 0)}
//   rmw_err_o            pulses in the merge cycle when a read-modify-write is aborted
//   mem_*                macro port (enable, write enable, address, write data, read data)
module sram_rmw_ctrl #(
    parameter int SramAw = 12,
    parameter int SramDw = 32,
    localparam int NumBytes = SramDw / 8,
`ifdef SRAM_RMW_PARITY_EN
    localparam int MemDw = SramDw + SramDw / 8
`else
    localparam int MemDw = SramDw
`endif
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic              we_i,
    input  logic [SramAw-1:0] addr_i,
    input  logic [SramDw-1:0] wdata_i,
    input  logic [SramDw-1:0] wmask_i,
    output logic [SramDw-1:0] rdata_o,
    output logic              rvalid_o,
    output logic [1:0]        rerror_o,
    output logic              rmw_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [SramAw-1:0] mem_addr_o,
    output logic [MemDw-1:0]  mem_wdata_o,
    input  logic [MemDw-1:0]  mem_rdata_i
);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              rvalid_q;
    logic              rd_issue;
    logic              latch_en;
    logic [SramAw-1:0] addr_q;
    logic [SramDw-1:0] wdata_q;
    logic [SramDw-1:0] wmask_q;
    logic              par_err;
    logic [SramDw-1:0] merged;

    function automatic logic [MemDw-1:0] encode(input logic [SramDw-1:0] d);
`ifdef SRAM_RMW_PARITY_EN
        logic [NumBytes-1:0] p;
        for (int b = 0; b < NumBytes; b++) begin
            p[b] = ^d[8*b +: 8];
        end
        return {p, d};
`else
        return d;
`endif
    endfunction

    // Even parity: a stored byte plus its parity bit must have an even number of ones.
`ifdef SRAM_RMW_PARITY_EN
    always_comb begin
        par_err = 1'b0;
        for (int b = 0; b < NumBytes; b++) begin
            if ((^mem_rdata_i[8*b +: 8]) != mem_rdata_i[SramDw + b]) begin
                par_err = 1'b1;
            end
        end
    end
`else
    assign par_err = 1'b0;
`endif

    assign merged = (mem_rdata_i[SramDw-1:0] & ~wmask_q) | (wdata_q & wmask_q);

    // The macro output is already registered, so read data is forwarded only in the rvalid cycle.
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rvalid_q ? mem_rdata_i[SramDw-1:0] : '0;
    assign rerror_o = {rvalid_q & par_err, 1'b0};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rd_issue;
            if (latch_en) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                wmask_q <= wmask_i;
            end
        end
    end

    // All macro activity is suppressed while reset is asserted, so a pending merge is discarded.
    always_comb begin
        state_d     = state_q;
        gnt_o       = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        rd_issue    = 1'b0;
        latch_en    = 1'b0;
        rmw_err_o   = 1'b0;
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        if (!we_i) begin
                            mem_req_o  = 1'b1;
                            mem_addr_o = addr_i;
                            gnt_o      = 1'b1;
                            rd_issue   = 1'b1;
                        end else if (&wmask_i) begin
                            mem_req_o   = 1'b1;
                            mem_we_o    = 1'b1;
                            mem_addr_o  = addr_i;
                            mem_wdata_o = encode(wdata_i);
                            gnt_o       = 1'b1;
                        end else if (wmask_i == '0) begin
                            gnt_o = 1'b1;
                        end else begin
                            // Partial write: fetch the old word now, merge next cycle.
                            mem_req_o  = 1'b1;
                            mem_addr_o = addr_i;
                            latch_en   = 1'b1;
                            state_d    = MERGE;
                        end
                    end
                end
                MERGE: begin
                    // The write completes even if req_i was dropped; only the grant follows req_i.
                    gnt_o       = req_i;
                    mem_addr_o  = addr_q;
                    mem_wdata_o = encode(merged);
                    if (par_err) begin
                        rmw_err_o = 1'b1;
                    end else begin
                        mem_req_o = 1'b1;
                        mem_we_o  = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// tb/tb_sram_rmw_ctrl.sv - directed self-checking bench for sram_rmw_ctrl with a behavioural macro
module tb_sram_rmw_ctrl;

    localparam int Aw = 12;
    localparam int Dw = 32;
`ifdef SRAM_RMW_PARITY_EN
    localparam int Mw = Dw + Dw / 8;
`else
    localparam int Mw = Dw;
`endif

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          req;
    logic          gnt;
    logic          we;
    logic [Aw-1:0] addr;
    logic [Dw-1:0] wdata;
    logic [Dw-1:0] wmask;
    logic [Dw-1:0] rdata;
    logic          rvalid;
    logic [1:0]    rerror;
    logic          rmw_err;
    logic          mem_req;
    logic          mem_we;
    logic [Aw-1:0] mem_addr;
    logic [Mw-1:0] mem_wdata;
    logic [Mw-1:0] mem_rdata;

    logic [Mw-1:0] mem [0:(1<<Aw)-1];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_rmw_ctrl dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_i      (req),
        .gnt_o      (gnt),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .wmask_i    (wmask),
        .rdata_o    (rdata),
        .rvalid_o   (rvalid),
        .rerror_o   (rerror),
        .rmw_err_o  (rmw_err),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    // Macro model: one-cycle registered read, no back-pressure.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic r, input logic w, input logic [Aw-1:0] a,
                         input logic [Dw-1:0] d, input logic [Dw-1:0] m);
        req = r; we = w; addr = a; wdata = d; wmask = m;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (rvalid !== 1'b0 || rdata !== 32'h0 || rerror !== 2'b00 || rmw_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: rvalid=%b rdata=%h rerror=%b rmw_err=%b required 0/0/00/0",
                     rvalid, rdata, rerror, rmw_err);
        end
        rst_ni = 1'b1;
        #1;
        checks++;
        if (gnt !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL idle_outputs: gnt=%b mem_req=%b mem_we=%b addr=%h wdata=%h required all 0",
                     gnt, mem_req, mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_full_write_read;
        @(negedge clk);
        drive(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 32'hFFFFFFFF);
        #1;
        checks++;
        if (gnt !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h010 ||
            mem_wdata[Dw-1:0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL full_write: gnt=%b req=%b we=%b addr=%h wdata=%h required 1/1/1/010/deadbeef",
                     gnt, mem_req, mem_we, mem_addr, mem_wdata[Dw-1:0]);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 12'h010, '0, '0);
        #1;
        checks++;
        if (rvalid !== 1'b0) begin
            failures++;
            $display("FAIL full_write_no_rvalid: rvalid=%b required 0", rvalid);
        end
        checks++;
        if (gnt !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h010) begin
            failures++;
            $display("FAIL read_issue: gnt=%b req=%b we=%b addr=%h required 1/1/0/010",
                     gnt, mem_req, mem_we, mem_addr);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rerror !== 2'b00) begin
            failures++;
            $display("FAIL read_data: rvalid=%b rdata=%h rerror=%b required 1/deadbeef/00",
                     rvalid, rdata, rerror);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rvalid_single: rvalid=%b required 0", rvalid);
        end
    endtask

    task automatic test_partial_write;
        @(negedge clk);
        drive(1'b1, 1'b1, 12'h020, 32'h11223344, 32'hFFFFFFFF);
        @(negedge clk);
        drive(1'b1, 1'b1, 12'h020, 32'h000000AA, 32'h000000FF);
        #1;
        checks++;
        if (gnt !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h020) begin
            failures++;
            $display("FAIL rmw_read: gnt=%b req=%b we=%b addr=%h required 0/1/0/020",
                     gnt, mem_req, mem_we, mem_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (gnt !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h020 ||
            mem_wdata[Dw-1:0] !== 32'h112233AA || rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rmw_merge: gnt=%b req=%b we=%b addr=%h wdata=%h rvalid=%b required 1/1/1/020/112233aa/0",
                     gnt, mem_req, mem_we, mem_addr, mem_wdata[Dw-1:0], rvalid);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 12'h020, '0, '0);
        #1;
        checks++;
        if (rvalid !== 1'b0 || gnt !== 1'b1) begin
            failures++;
            $display("FAIL rmw_after: rvalid=%b gnt=%b required 0/1", rvalid, gnt);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h112233AA) begin
            failures++;
            $display("FAIL rmw_readback: rvalid=%b rdata=%h required 1/112233aa", rvalid, rdata);
        end
    endtask

    task automatic test_req_drop_in_merge;
        mem[12'h060] = Mw'(32'hAABBCCDD);
        @(negedge clk);
        drive(1'b1, 1'b1, 12'h060, 32'h00110000, 32'h00FF0000);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (gnt !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h060 ||
            mem_wdata[Dw-1:0] !== 32'hAA11CCDD) begin
            failures++;
            $display("FAIL req_drop_merge: gnt=%b req=%b we=%b addr=%h wdata=%h required 0/1/1/060/aa11ccdd",
                     gnt, mem_req, mem_we, mem_addr, mem_wdata[Dw-1:0]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem[12'h060][Dw-1:0] !== 32'hAA11CCDD || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL req_drop_stored: mem=%h mem_req=%b required aa11ccdd/0",
                     mem[12'h060][Dw-1:0], mem_req);
        end
    endtask

    task automatic test_back_to_back;
        logic [Dw-1:0] exp_d [0:2];
        exp_d[0] = 32'hA1A1A1A1;
        exp_d[1] = 32'hB2B2B2B2;
        exp_d[2] = 32'hC3C3C3C3;
        for (int i = 0; i < 3; i++) mem[i+1] = Mw'(exp_d[i]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) drive(1'b1, 1'b0, Aw'(i + 1), '0, '0);
            else       drive(1'b0, 1'b0, '0, '0, '0);
            #1;
            if (i < 3) begin
                checks++;
                if (gnt !== 1'b1 || mem_addr !== Aw'(i + 1)) begin
                    failures++;
                    $display("FAIL b2b_gnt[%0d]: gnt=%b addr=%h required 1/%h", i, gnt, mem_addr, i + 1);
                end
            end
            if (i > 0) begin
                checks++;
                if (rvalid !== 1'b1 || rdata !== exp_d[i-1]) begin
                    failures++;
                    $display("FAIL b2b_data[%0d]: rvalid=%b rdata=%h required 1/%h", i - 1, rvalid, rdata, exp_d[i-1]);
                end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (rvalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: rvalid=%b required 0", rvalid);
        end
    endtask

    task automatic test_zero_mask;
        mem[12'h030] = Mw'(32'h55555555);
        @(negedge clk);
        drive(1'b1, 1'b1, 12'h030, 32'h12345678, 32'h00000000);
        #1;
        checks++;
        if (gnt !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL zero_mask: gnt=%b mem_req=%b mem_we=%b required 1/0/0", gnt, mem_req, mem_we);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 12'h030, '0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h55555555) begin
            failures++;
            $display("FAIL zero_mask_read: rvalid=%b rdata=%h required 1/55555555", rvalid, rdata);
        end
    endtask

    task automatic test_reset_in_merge;
        mem[12'h040] = '0;
        @(negedge clk);
        drive(1'b1, 1'b1, 12'h040, 32'h0000FF00, 32'h0000FF00);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || gnt !== 1'b0 || rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_merge: mem_req=%b mem_we=%b gnt=%b rvalid=%b required 0/0/0/0",
                     mem_req, mem_we, gnt, rvalid);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        drive(1'b1, 1'b0, 12'h040, '0, '0);
        #1;
        checks++;
        if (rvalid !== 1'b0 || gnt !== 1'b1 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_merge_after: rvalid=%b gnt=%b mem_we=%b required 0/1/0", rvalid, gnt, mem_we);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h00000000) begin
            failures++;
            $display("FAIL reset_merge_read: rvalid=%b rdata=%h required 1/00000000", rvalid, rdata);
        end
    endtask

`ifdef SRAM_RMW_PARITY_EN
    task automatic test_parity;
        logic [Mw-1:0] saved;
        @(negedge clk);
        drive(1'b1, 1'b1, 12'h050, 32'h12345678, 32'hFFFFFFFF);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        mem[12'h050][Dw] = ~mem[12'h050][Dw];
        saved = mem[12'h050];
        @(negedge clk);
        drive(1'b1, 1'b0, 12'h050, '0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (rvalid !== 1'b1 || rerror !== 2'b10) begin
            failures++;
            $display("FAIL parity_read: rvalid=%b rerror=%b required 1/10", rvalid, rerror);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 12'h050, 32'h000000AA, 32'h000000FF);
        @(negedge clk);
        #1;
        checks++;
        if (rmw_err !== 1'b1 || gnt !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL parity_rmw: rmw_err=%b gnt=%b mem_req=%b required 1/1/0", rmw_err, gnt, mem_req);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (rmw_err !== 1'b0 || mem[12'h050] !== saved) begin
            failures++;
            $display("FAIL parity_unchanged: rmw_err=%b mem=%h required 0/%h", rmw_err, mem[12'h050], saved);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << Aw); i++) mem[i] = '0;
        mem_rdata = '0;
        test_reset;
        test_full_write_read;
        test_partial_write;
        test_req_drop_in_merge;
        test_back_to_back;
        test_zero_mask;
        test_reset_in_merge;
`ifdef SRAM_RMW_PARITY_EN
        test_parity;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
